// File: rtl/seven_segment_scan.sv
// seven_segment_scan
//   Multiplexed hex display driver. Time-shares one 7-segment bus across
//   DIGITS digit enables. The value, decimal points and digit enables are
//   snapshotted once per full scan so the display never tears. Each digit
//   slot opens with DEAD_CYCLES of dead time (all anodes off) to stop
//   ghosting. Leading-zero blanking and the output polarity are both
//   selectable.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   enable     1 = scan runs; 0 = freeze scan with the display dark
//   value      4*DIGITS hex value; nibble i is shown on digit i (0 = rightmost)
//   dp         decimal point request per digit
//   digit_en   per-digit enable; 0 blanks that digit
//   segments   {a,b,c,d,e,f,g}, bit 6 = a
//   dp_out     decimal point segment
//   anodes     one-hot digit select
//   scan_done  1-cycle pulse when a full scan completes (snapshot taken)
module seven_segment_scan #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_CYCLES = 100000,
  parameter int DEAD_CYCLES    = 1,
  parameter int LZ_BLANK       = 0,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     digit_en,
  output logic [6:0]            segments,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     anodes,
  output logic                  scan_done
);

  localparam int PS_W  = $clog2(REFRESH_CYCLES);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(REFRESH_CYCLES - 1);
  localparam logic [PS_W-1:0]  PS_DEAD  = PS_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic             INV      = (ACTIVE_LOW != 0);

  logic [PS_W-1:0]     ps_cnt_q, ps_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_val_q, snap_val_d;
  logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [DIGITS-1:0]   snap_en_q, snap_en_d;
  logic                scan_done_q, scan_done_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_out_q, dp_out_d;
  logic [DIGITS-1:0]   anodes_q, anodes_d;

  logic                tick;
  logic                take;
  logic                digit_on;
  logic                zeros_above;
  logic [DIGITS-1:0]   lz_mask;
  logic [DIGITS-1:0]   an_on;
  logic [3:0]          cur_nib;

  function automatic logic [6:0] font7(input logic [3:0] n);
    case (n)
      4'h0: font7 = 7'b1111110;
      4'h1: font7 = 7'b0110000;
      4'h2: font7 = 7'b1101101;
      4'h3: font7 = 7'b1111001;
      4'h4: font7 = 7'b0110011;
      4'h5: font7 = 7'b1011011;
      4'h6: font7 = 7'b1011111;
      4'h7: font7 = 7'b1110000;
      4'h8: font7 = 7'b1111111;
      4'h9: font7 = 7'b1110011;
      4'hA: font7 = 7'b1110111;
      4'hB: font7 = 7'b0011111;
      4'hC: font7 = 7'b1001110;
      4'hD: font7 = 7'b0111101;
      4'hE: font7 = 7'b1001111;
      default: font7 = 7'b1000111;
    endcase
  endfunction

  // Scan timing and snapshot capture.
  always_comb begin
    tick        = enable && (ps_cnt_q == PS_LAST);
    take        = tick && (idx_q == IDX_LAST);
    ps_cnt_d    = ps_cnt_q;
    idx_d       = idx_q;
    snap_val_d  = snap_val_q;
    snap_dp_d   = snap_dp_q;
    snap_en_d   = snap_en_q;
    scan_done_d = take;
    if (enable) ps_cnt_d = tick ? '0 : ps_cnt_q + 1'b1;
    if (tick)   idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    if (take) begin
      snap_val_d = value;
      snap_dp_d  = dp;
      snap_en_d  = digit_en;
    end
  end

  // Leading-zero mask: walk from the top digit down, blanking zeros until
  // the first non-zero nibble. Digit 0 is never part of the walk.
  always_comb begin
    lz_mask     = '0;
    zeros_above = 1'b1;
    if (LZ_BLANK != 0) begin
      for (int unsigned k = 0; k < DIGITS - 1; k++) begin
        if (zeros_above && (snap_val_q[4*(DIGITS-1-k) +: 4] == 4'h0))
          lz_mask[DIGITS-1-k] = 1'b1;
        else
          zeros_above = 1'b0;
      end
    end
  end

  // Output decode, registered with polarity applied at the flop input.
  always_comb begin
    cur_nib  = snap_val_q[{idx_q, 2'b00} +: 4];
    digit_on = enable && (ps_cnt_q >= PS_DEAD) && snap_en_q[idx_q] && !lz_mask[idx_q];
    an_on    = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (digit_on && (idx_q == IDX_W'(i))) an_on[i] = 1'b1;
    end
    seg_d    = (digit_on ? font7(cur_nib) : 7'b0000000) ^ {7{INV}};
    dp_out_d = (digit_on && snap_dp_q[idx_q]) ^ INV;
    anodes_d = an_on ^ {DIGITS{INV}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_cnt_q    <= '0;
      idx_q       <= '0;
      snap_val_q  <= '0;
      snap_dp_q   <= '0;
      snap_en_q   <= '0;
      scan_done_q <= 1'b0;
      seg_q       <= {7{INV}};
      dp_out_q    <= INV;
      anodes_q    <= {DIGITS{INV}};
    end else begin
      ps_cnt_q    <= ps_cnt_d;
      idx_q       <= idx_d;
      snap_val_q  <= snap_val_d;
      snap_dp_q   <= snap_dp_d;
      snap_en_q   <= snap_en_d;
      scan_done_q <= scan_done_d;
      seg_q       <= seg_d;
      dp_out_q    <= dp_out_d;
      anodes_q    <= anodes_d;
    end
  end

  assign segments  = seg_q;
  assign dp_out    = dp_out_q;
  assign anodes    = anodes_q;
  assign scan_done = scan_done_q;

endmodule
